// File: rtl/led_pkg.sv
// LED command sequencer shared definitions.
// Command encodings, FSM states and tick-count defaults.
package led_pkg;

    localparam logic [1:0] LED_CMD_OFF  = 2'b00;
    localparam logic [1:0] LED_CMD_ON   = 2'b01;
    localparam logic [1:0] LED_CMD_SLOW = 2'b10;
    localparam logic [1:0] LED_CMD_FAST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFF_PH = 2'd1,
        ST_ON_PH  = 2'd2
    } led_state_e;

    localparam int DEF_CLKS_PER_TICK  = 1200000;
    localparam int DEF_SLOW_OFF_TICKS = 5;
    localparam int DEF_SLOW_ON_TICKS  = 10;
    localparam int DEF_SLOW_REPS      = 3;
    localparam int DEF_FAST_TICKS     = 2;
    localparam int DEF_FAST_REPS      = 5;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLKS_PER_TICK clocks.
// A synchronous clear restarts the count from zero.
module tick_gen #(
    parameter int CLKS_PER_TICK = 1200000
) (
    input  logic hwclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Free-running count, wrapped on tick, restarted on clear
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/led_cmd_sequencer.sv
// LED command sequencer: static on/off and timed blink patterns.
// Blink phases are counted in prescaled ticks; abort cancels a blink.
module led_cmd_sequencer
    import led_pkg::*;
#(
    parameter int CLKS_PER_TICK  = DEF_CLKS_PER_TICK,
    parameter int SLOW_OFF_TICKS = DEF_SLOW_OFF_TICKS,
    parameter int SLOW_ON_TICKS  = DEF_SLOW_ON_TICKS,
    parameter int SLOW_REPS      = DEF_SLOW_REPS,
    parameter int FAST_TICKS     = DEF_FAST_TICKS,
    parameter int FAST_REPS      = DEF_FAST_REPS
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       led_on,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] SLOW_OFF_LAST = 4'(SLOW_OFF_TICKS - 1);
    localparam logic [3:0] SLOW_ON_LAST  = 4'(SLOW_ON_TICKS - 1);
    localparam logic [3:0] FAST_LAST     = 4'(FAST_TICKS - 1);
    localparam logic [2:0] SLOW_REPS_INIT = 3'(SLOW_REPS);
    localparam logic [2:0] FAST_REPS_INIT = 3'(FAST_REPS);

    led_state_e state_q, state_d;
    logic       led_d, busy_d, done_d;
    logic       fast_q, fast_d;
    logic [3:0] ticks_q, ticks_d, phase_last;
    logic [2:0] reps_q, reps_d;
    logic       tick, tick_clr, phase_end;

    tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .hwclk(hwclk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign phase_end = tick && (ticks_q == phase_last);

    // Last tick index of the current phase, by blink speed and phase
    always_comb begin
        phase_last = SLOW_OFF_LAST;
        if (fast_q) begin
            phase_last = FAST_LAST;
        end else if (state_q == ST_ON_PH) begin
            phase_last = SLOW_ON_LAST;
        end
    end

    // Next-state, counter and registered-output decisions
    always_comb begin
        state_d  = state_q;
        led_d    = led_on;
        busy_d   = busy;
        done_d   = 1'b0;
        fast_d   = fast_q;
        reps_d   = reps_q;
        ticks_d  = ticks_q;
        tick_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tick_clr = 1'b1;
                ticks_d  = '0;
                if (cmd_valid) begin
                    unique case (cmd)
                        LED_CMD_OFF: begin
                            led_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        LED_CMD_ON: begin
                            led_d  = 1'b1;
                            done_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_OFF_PH;
                            led_d   = 1'b0;
                            busy_d  = 1'b1;
                            fast_d  = (cmd == LED_CMD_FAST);
                            reps_d  = (cmd == LED_CMD_FAST) ?
                                      FAST_REPS_INIT : SLOW_REPS_INIT;
                        end
                    endcase
                end
            end
            ST_OFF_PH: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    led_d    = 1'b0;
                    busy_d   = 1'b0;
                    reps_d   = '0;
                    ticks_d  = '0;
                    tick_clr = 1'b1;
                end else if (phase_end) begin
                    state_d  = ST_ON_PH;
                    led_d    = 1'b1;
                    ticks_d  = '0;
                    tick_clr = 1'b1;
                end else if (tick) begin
                    ticks_d = ticks_q + 4'd1;
                end
            end
            ST_ON_PH: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    led_d    = 1'b0;
                    busy_d   = 1'b0;
                    reps_d   = '0;
                    ticks_d  = '0;
                    tick_clr = 1'b1;
                end else if (phase_end) begin
                    ticks_d  = '0;
                    tick_clr = 1'b1;
                    led_d    = 1'b0;
                    if (reps_q > 3'd1) begin
                        reps_d  = reps_q - 3'd1;
                        state_d = ST_OFF_PH;
                    end else begin
                        reps_d  = '0;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (tick) begin
                    ticks_d = ticks_q + 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                led_d    = 1'b0;
                busy_d   = 1'b0;
                reps_d   = '0;
                ticks_d  = '0;
                tick_clr = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            led_on  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fast_q  <= 1'b0;
            reps_q  <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            led_on  <= led_d;
            busy    <= busy_d;
            done    <= done_d;
            fast_q  <= fast_d;
            reps_q  <= reps_d;
            ticks_q <= ticks_d;
        end
    end

endmodule
